// File: rtl/sa_pkg.sv
// Shared definitions for the systolic-array datapath.
// Provides the lane width, a lane-slice offset helper for packing/unpacking
// result vectors, and the signed 32-bit ReLU used at result capture.
package sa_pkg;

   localparam int unsigned LANE_W = 32;

   // Bit offset of lane 'lane' inside a packed vector of LANE_W-bit lanes.
   function automatic int unsigned lane_lsb(input int unsigned lane);
      return lane * LANE_W;
   endfunction

   // Two's-complement ReLU: negative words become zero, others pass unchanged.
   function automatic logic [LANE_W-1:0] relu(input logic [LANE_W-1:0] x);
      return x[LANE_W-1] ? '0 : x;
   endfunction

endpackage

// File: rtl/sa_result_drain_if.sv
// Lane-serial result stream toward the DMA / AXI-Stream writer.
//   out_data  : current lane word
//   out_valid : out_data valid
//   out_last  : final lane of the vector
//   out_ready : sink accepts the word when high together with out_valid
// master = drain side, slave = sink side.
interface sa_result_drain_if;
   import sa_pkg::*;

   logic [LANE_W-1:0] out_data;
   logic              out_valid;
   logic              out_last;
   logic              out_ready;

   modport master (output out_data, output out_valid, output out_last, input out_ready);
   modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/sa_vec_fifo.sv
// Synchronous vector FIFO with an explicit occupancy counter.
//   clk, res      : clock, synchronous active-high reset
//   push / wdata  : write request and data (ignored when full without a pop)
//   pop           : frees the head entry (ignored when empty)
//   rdata         : head entry
//   count         : entries held (0..DEPTH)
//   full / empty  : occupancy flags
module sa_vec_fifo #(
   parameter  int unsigned WIDTH = 128,
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             res,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [PTR_W:0]   count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (PTR_W+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign rdata = mem_q[rd_ptr_q];

   // A push into a full FIFO is legal only when the head is freed on the same edge.
   always_comb begin
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the entry at rd_ptr is never the write target unless it is being freed.
   always_ff @(posedge clk) begin
      if (!res && do_push) mem_q[wr_ptr_q] <= wdata;
   end

endmodule

// File: rtl/sa_result_drain.sv
// Result drain for the systolic array: captures each SoutL vector (qualified
// by Sready, optionally ReLU'd) into a vector FIFO and serialises it lane by
// lane onto a 32-bit valid/ready stream with a last flag on the final lane.
//   clk, res     : clock, synchronous active-high reset
//   SoutL/Sready : result vector and its single-cycle valid pulse
//   relu_en      : apply ReLU to lanes at capture
//   strm         : lane-serial output stream (master side)
//   overflow     : sticky, a vector arrived while full and was dropped
//   fifo_count   : vectors held, including the one being serialised
module sa_result_drain
   import sa_pkg::*;
#(
   parameter  int unsigned ARRAY_LENGTH = 4,
   parameter  int unsigned FIFO_DEPTH   = 4,
   localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH)
) (
   input  logic                           clk,
   input  logic                           res,
   input  logic [ARRAY_LENGTH*LANE_W-1:0] SoutL,
   input  logic                           Sready,
   input  logic                           relu_en,
   sa_result_drain_if.master              strm,
   output logic                           overflow,
   output logic [PTR_W:0]                 fifo_count
);

   localparam int unsigned VEC_W  = ARRAY_LENGTH * LANE_W;
   localparam int unsigned LIDX_W = (ARRAY_LENGTH > 1) ? $clog2(ARRAY_LENGTH) : 1;
   localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(ARRAY_LENGTH - 1);

   logic [LIDX_W-1:0] lane_idx_q, lane_idx_d;
   logic              overflow_q, overflow_d;
   logic [VEC_W-1:0]  cap_vec;
   logic [VEC_W-1:0]  head_vec;
   logic [LANE_W-1:0] head_lanes [ARRAY_LENGTH];
   logic              fifo_full, fifo_empty;
   logic              push, pop, xfer;

   // Capture path: lane-wise ReLU applied before the vector is stored.
   always_comb begin
      logic [LANE_W-1:0] lane;
      cap_vec = '0;
      lane    = '0;
      for (int unsigned i = 0; i < ARRAY_LENGTH; i++) begin
         lane = SoutL[lane_lsb(i) +: LANE_W];
         cap_vec[lane_lsb(i) +: LANE_W] = relu_en ? relu(lane) : lane;
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < ARRAY_LENGTH; i++) begin
         head_lanes[i] = head_vec[lane_lsb(i) +: LANE_W];
      end
   end

   // Serialiser: present lane_idx of the head entry; free the entry on the last transfer.
   always_comb begin
      strm.out_valid = !fifo_empty;
      strm.out_last  = !fifo_empty && (lane_idx_q == LAST_LANE);
      strm.out_data  = fifo_empty ? '0 : head_lanes[lane_idx_q];
      xfer           = strm.out_valid && strm.out_ready;
      pop            = xfer && strm.out_last;
      push           = Sready && (!fifo_full || pop);
      lane_idx_d     = lane_idx_q;
      if (xfer) lane_idx_d = strm.out_last ? '0 : lane_idx_q + 1'b1;
      overflow_d     = overflow_q || (Sready && fifo_full && !pop);
   end

   always_ff @(posedge clk) begin
      if (res) begin
         lane_idx_q <= '0;
         overflow_q <= 1'b0;
      end else begin
         lane_idx_q <= lane_idx_d;
         overflow_q <= overflow_d;
      end
   end

   assign overflow = overflow_q;

   sa_vec_fifo #(
      .WIDTH (VEC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .res   (res),
      .push  (push),
      .pop   (pop),
      .wdata (cap_vec),
      .rdata (head_vec),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule
